// File: rtl/light_pkg.sv
// Shared definitions for the traffic-light toggle driver: light codes, FSM encoding and
// the phase hold-time lookup.
package light_pkg;

  localparam logic [1:0] LIGHT_GREEN  = 2'b01;
  localparam logic [1:0] LIGHT_YELLOW = 2'b11;
  localparam logic [1:0] LIGHT_RED    = 2'b10;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StPulse = 2'b01,
    StWait  = 2'b10
  } drv_state_e;

  // Illegal code 00 falls back to the green hold time.
  function automatic int unsigned hold_cycles(input logic [1:0]  code,
                                              input int unsigned green,
                                              input int unsigned yellow,
                                              input int unsigned red);
    case (code)
      LIGHT_YELLOW: hold_cycles = yellow;
      LIGHT_RED:    hold_cycles = red;
      default:      hold_cycles = green;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button front end: two-flop synchroniser, consecutive-sample debounce and a
// one-cycle pulse on each accepted rising edge of the debounced level.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw_i,
  output logic btn_level_o,
  output logic man_req_o
);

  localparam logic [CNT_W-1:0] DebLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic             level_prev_q;
  logic             man_req_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count consecutive samples that disagree with the accepted level; any agreement restarts.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q >= DebLast) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      man_req_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_raw_i;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      man_req_q    <= level_q & ~level_prev_q;
      cnt_q        <= cnt_d;
    end
  end

  assign btn_level_o = level_q;
  assign man_req_o   = man_req_q;

endmodule

// File: rtl/light_toggle_driver.sv
// Drives the red_toggle pulse that advances the light stage, merging debounced button presses
// with an automatic phase timer and checking that the light actually moved on.
module light_toggle_driver
  import light_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned GREEN_CYCLES    = 20,
  parameter int unsigned YELLOW_CYCLES   = 5,
  parameter int unsigned RED_CYCLES      = 15,
  parameter int unsigned ACK_TIMEOUT     = 4,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw_i,
  input  logic       auto_en_i,
  input  logic [1:0] light_state_i,
  output logic       red_toggle_o,
  output logic       btn_level_o,
  output logic       busy_o,
  output logic       ack_fault_o
);

  localparam logic [CNT_W-1:0] AckLoad = CNT_W'(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] AckOne  = CNT_W'(1);

  drv_state_e       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] ack_cnt_q, ack_cnt_d;
  logic [1:0]       prev_light_q, prev_light_d;
  logic [1:0]       cap_q, cap_d;
  logic             pending_q, pending_d;
  logic             fault_q, fault_d;
  logic             red_toggle_q;
  logic             busy_q;
  logic             man_req;
  logic             auto_req;
  logic             req;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_btn_debounce (
    .clk        (clk),
    .rst        (rst),
    .btn_raw_i  (btn_raw_i),
    .btn_level_o(btn_level_o),
    .man_req_o  (man_req)
  );

  // Phase timer: reload on any light change, otherwise count down to zero while enabled.
  always_comb begin
    timer_d      = timer_q;
    prev_light_d = prev_light_q;
    if (light_state_i != prev_light_q) begin
      timer_d      = CNT_W'(hold_cycles(light_state_i, GREEN_CYCLES, YELLOW_CYCLES,
                                        RED_CYCLES));
      prev_light_d = light_state_i;
    end else if (auto_en_i && (timer_q != '0)) begin
      timer_d = timer_q - 1'b1;
    end
  end

  // A latched fault stops the timer from re-requesting forever against a stuck light.
  assign auto_req = (timer_q == '0) && auto_en_i && (state_q == StIdle) && !fault_q;
  assign req      = man_req | auto_req | pending_q;

  always_comb begin
    state_d   = state_q;
    cap_d     = cap_q;
    ack_cnt_d = ack_cnt_q;
    pending_d = pending_q;
    fault_d   = fault_q;

    if (man_req && (state_q != StIdle)) begin
      pending_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d   = StPulse;
          pending_d = 1'b0;
        end
      end
      StPulse: begin
        cap_d     = light_state_i;
        ack_cnt_d = AckLoad;
        state_d   = StWait;
      end
      StWait: begin
        if (light_state_i != cap_q) begin
          state_d = StIdle;
        end else begin
          ack_cnt_d = ack_cnt_q - 1'b1;
          if (ack_cnt_q <= AckOne) begin
            ack_cnt_d = '0;
            fault_d   = 1'b1;
            state_d   = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      timer_q      <= CNT_W'(GREEN_CYCLES);
      ack_cnt_q    <= '0;
      prev_light_q <= LIGHT_GREEN;
      cap_q        <= LIGHT_GREEN;
      pending_q    <= 1'b0;
      fault_q      <= 1'b0;
      red_toggle_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      ack_cnt_q    <= ack_cnt_d;
      prev_light_q <= prev_light_d;
      cap_q        <= cap_d;
      pending_q    <= pending_d;
      fault_q      <= fault_d;
      // Registered decode keeps the pulse glitch-free toward the light stage.
      red_toggle_q <= (state_d == StPulse);
      busy_q       <= (state_d != StIdle);
    end
  end

  assign red_toggle_o = red_toggle_q;
  assign busy_o       = busy_q;
  assign ack_fault_o  = fault_q;

endmodule

// File: tb/tb_light_toggle_driver.sv
// Scoreboard bench: every request pushes the cycle its pulse must appear in; the monitor pops
// and compares on each observed pulse, with a behavioural light stage closing the loop.
module tb_light_toggle_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_raw;
  logic       auto_en;
  logic [1:0] light;
  logic       red_toggle;
  logic       btn_level;
  logic       busy;
  logic       ack_fault;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   exp_q[$];
  int   a;
  logic model_en = 1'b0;
  logic red_prev;
  logic lvl_seen;

  light_toggle_driver #(
    .DEBOUNCE_CYCLES(4),
    .GREEN_CYCLES   (20),
    .YELLOW_CYCLES  (5),
    .RED_CYCLES     (15),
    .ACK_TIMEOUT    (4),
    .CNT_W          (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_raw_i    (btn_raw),
    .auto_en_i    (auto_en),
    .light_state_i(light),
    .red_toggle_o (red_toggle),
    .btn_level_o  (btn_level),
    .busy_o       (busy),
    .ack_fault_o  (ack_fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [1:0] next_code(input logic [1:0] c);
    case (c)
      2'b01:   next_code = 2'b11;
      2'b11:   next_code = 2'b10;
      default: next_code = 2'b01;
    endcase
  endfunction

  function automatic int hold_of(input logic [1:0] c);
    case (c)
      2'b11:   hold_of = 5;
      2'b10:   hold_of = 15;
      default: hold_of = 20;
    endcase
  endfunction

  // Monitor plus light-stage model: the light advances one negedge after the pulse falls,
  // so the driver sees the new code at the following posedge and reloads there.
  initial begin
    light    = 2'b01;
    red_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (red_toggle) begin
        check("pulse_gap", int'(red_prev), 0);
        if (exp_q.size() == 0) check("pulse_expected", exp_q.size(), 1);
        else check("pulse_cycle", cyc, exp_q.pop_front());
      end
      if (model_en && red_prev && !red_toggle) begin
        light = next_code(light);
        if (auto_en) exp_q.push_back(cyc + hold_of(light) + 2);
      end
      red_prev = red_toggle;
    end
  end

  task automatic wait_pulse(input int max_cyc, input string tag);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!red_toggle && k < max_cyc);
    if (!red_toggle) check(tag, int'(red_toggle), 1);
  endtask

  initial begin
    rst = 1'b1; btn_raw = 1'b0; auto_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_red", int'(red_toggle), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_fault", int'(ack_fault), 0);
    check("rst_level", int'(btn_level), 0);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("idle_busy", int'(busy), 0);
    check("idle_fault", int'(ack_fault), 0);

    // Clean press: sampled at cyc+1, level after +6, pulse at +8.
    model_en = 1'b1;
    a = cyc;
    btn_raw = 1'b1;
    exp_q.push_back(a + 8);
    repeat (5) @(negedge clk);
    check("press_lvl_early", int'(btn_level), 0);
    repeat (2) @(negedge clk);
    check("press_lvl", int'(btn_level), 1);
    repeat (15) @(negedge clk);
    btn_raw = 1'b0;
    repeat (15) @(negedge clk);
    check("press_drained", exp_q.size(), 0);

    // Bounce: single-cycle glitches must never reach the debounced level.
    lvl_seen = 1'b0;
    for (int i = 0; i < 19; i++) begin
      btn_raw = (i < 4) && (i % 2 == 0);
      @(negedge clk);
      lvl_seen = lvl_seen | btn_level;
    end
    check("bounce_level", int'(lvl_seen), 0);
    check("bounce_busy", int'(busy), 0);

    // Auto cycling from yellow (timer frozen at 5): yellow -> red -> green -> yellow.
    a = cyc;
    auto_en = 1'b1;
    exp_q.push_back(a + 6);
    wait_pulse(40, "auto_p1");
    wait_pulse(40, "auto_p2");
    wait_pulse(40, "auto_p3");
    auto_en = 1'b0;
    repeat (10) @(negedge clk);
    check("auto_drained", exp_q.size(), 0);

    // Freeze: two decrements, hold, then the remaining three.
    auto_en = 1'b1;
    repeat (2) @(negedge clk);
    auto_en = 1'b0;
    repeat (10) @(negedge clk);
    auto_en = 1'b1;
    exp_q.push_back(cyc + 4);
    wait_pulse(20, "freeze_p");
    auto_en = 1'b0;
    repeat (10) @(negedge clk);
    check("freeze_drained", exp_q.size(), 0);

    // Collision: red hold 15 expires the same cycle the press is accepted -> one pulse.
    a = cyc;
    auto_en = 1'b1;
    exp_q.push_back(a + 16);
    repeat (8) @(negedge clk);
    btn_raw = 1'b1;
    wait_pulse(20, "coll_p");
    auto_en = 1'b0;
    repeat (12) @(negedge clk);
    btn_raw = 1'b0;
    repeat (15) @(negedge clk);
    check("coll_drained", exp_q.size(), 0);

    // Manual press green -> yellow, then freeze the light stage at yellow.
    btn_raw = 1'b1;
    exp_q.push_back(cyc + 8);
    repeat (12) @(negedge clk);
    btn_raw = 1'b0;
    repeat (15) @(negedge clk);
    model_en = 1'b0;

    // Stuck light: four WAIT cycles then a sticky fault.
    a = cyc;
    btn_raw = 1'b1;
    exp_q.push_back(a + 8);
    repeat (12) @(negedge clk);
    check("stuck_fault_early", int'(ack_fault), 0);
    check("stuck_busy_wait", int'(busy), 1);
    @(negedge clk);
    check("stuck_fault", int'(ack_fault), 1);
    check("stuck_busy_idle", int'(busy), 0);
    btn_raw = 1'b0;
    repeat (15) @(negedge clk);
    auto_en = 1'b1;
    repeat (20) @(negedge clk);
    auto_en = 1'b0;
    check("fault_sticky", int'(ack_fault), 1);
    check("fault_drained", exp_q.size(), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_clears_fault", int'(ack_fault), 0);
    check("rst_busy2", int'(busy), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Pending: auto pulse from yellow, press lands in WAIT and re-issues after IDLE.
    model_en = 1'b1;
    a = cyc;
    auto_en = 1'b1;
    btn_raw = 1'b1;
    exp_q.push_back(a + 6);
    exp_q.push_back(a + 9);
    wait_pulse(15, "pend_p1");
    auto_en = 1'b0;
    wait_pulse(10, "pend_p2");
    repeat (8) @(negedge clk);
    btn_raw = 1'b0;
    repeat (15) @(negedge clk);
    check("pend_drained", exp_q.size(), 0);

    // Reset in the middle of a pulse drops it at that edge.
    model_en = 1'b0;
    btn_raw = 1'b1;
    exp_q.push_back(cyc + 8);
    wait_pulse(15, "rstmid_p");
    rst = 1'b1;
    btn_raw = 1'b0;
    @(negedge clk);
    check("rstmid_red", int'(red_toggle), 0);
    check("rstmid_busy", int'(busy), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("final_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
